// File: rtl/alu_pwr_pkg.sv
// Shared types and default timing for the ALU power sequencer.
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PUP    = 3'd1,
    ST_ISOREL = 3'd2,
    ST_ON     = 3'd3,
    ST_RUN    = 3'd4,
    ST_ISOSET = 3'd5,
    ST_PDN    = 3'd6
  } pwr_state_e;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_OP_W       = 4;
  localparam int DEF_PWR_UP_CYC = 4;
  localparam int DEF_PWR_DN_CYC = 2;
  localparam int DEF_IDLE_CYC   = 16;
  localparam int DEF_WDOG_CYC   = 64;

  // Width needed to hold n-1 (timers are loaded with cycles-1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_pwr_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module alu_pwr_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = load_val;
    else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// Always-on power sequencer for the gated ALU domain: power/isolation control,
// operand launch and result retention. ALU_PWR_WDOG_EN adds a RUN watchdog.
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int OP_W       = DEF_OP_W,
  parameter int PWR_UP_CYC = DEF_PWR_UP_CYC,
  parameter int PWR_DN_CYC = DEF_PWR_DN_CYC,
  parameter int IDLE_CYC   = DEF_IDLE_CYC,
  parameter int WDOG_CYC   = DEF_WDOG_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   opcode,
  input  logic              pd_req,
  output logic              alu_pwr_en,
  output logic              alu_iso_en,
  output logic              alu_start,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic              alu_busy,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] result,
  output logic              res_err,
  output logic [2:0]        pwr_state
);

  localparam int PWR_MAX = (PWR_UP_CYC > PWR_DN_CYC) ? PWR_UP_CYC : PWR_DN_CYC;
  localparam int PW      = cnt_w(PWR_MAX);
  localparam int IW      = cnt_w(IDLE_CYC);

  pwr_state_e state_q, state_d;

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              start_q, start_d, rv_q, rv_d, err_q, err_d;
  logic [1:0]        run_cnt_q, run_cnt_d;

  logic accept, complete, wdog_abort, idle_hit;
  logic pwr_load, pwr_done, idle_load, idle_done;
  logic [PW-1:0] pwr_val;

  assign accept   = (state_q == ST_ON) && req_valid;
  // ALU busy may still read low right after start; ignore it for two cycles.
  assign complete = (state_q == ST_RUN) && !alu_busy && (run_cnt_q == 2'd2);
  assign idle_hit = (IDLE_CYC != 0) && idle_done;

  assign pwr_load  = (state_d != state_q) && ((state_d == ST_PUP) || (state_d == ST_PDN));
  assign pwr_val   = (state_d == ST_PUP) ? PW'(PWR_UP_CYC - 1) : PW'(PWR_DN_CYC - 1);
  assign idle_load = (state_d == ST_ON) && (state_q != ST_ON);

  alu_pwr_timer #(.W(PW)) u_pwr_tmr (
    .clk(clk), .rst_n(rst_n), .load(pwr_load), .load_val(pwr_val), .done(pwr_done)
  );

  alu_pwr_timer #(.W(IW)) u_idle_tmr (
    .clk(clk), .rst_n(rst_n), .load(idle_load),
    .load_val(IW'((IDLE_CYC == 0) ? 0 : IDLE_CYC - 1)), .done(idle_done)
  );

`ifdef ALU_PWR_WDOG_EN
  localparam int WW = cnt_w(WDOG_CYC);
  logic wdog_load, wdog_done;

  assign wdog_load  = (state_d == ST_RUN) && (state_q != ST_RUN);
  assign wdog_abort = (state_q == ST_RUN) && wdog_done && !complete;

  alu_pwr_timer #(.W(WW)) u_wdog_tmr (
    .clk(clk), .rst_n(rst_n), .load(wdog_load), .load_val(WW'(WDOG_CYC - 1)), .done(wdog_done)
  );
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYC;
  assign wdog_abort  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:    if (req_valid) state_d = ST_PUP;
      ST_PUP:    if (pwr_done)  state_d = ST_ISOREL;
      ST_ISOREL:                state_d = ST_ON;
      ST_ON: begin
        if (req_valid)                state_d = ST_RUN;
        else if (pd_req || idle_hit)  state_d = ST_ISOSET;
      end
      ST_RUN: begin
        if (complete)        state_d = ST_ON;
        else if (wdog_abort) state_d = ST_ISOSET;
      end
      ST_ISOSET:                state_d = ST_PDN;
      ST_PDN:    if (pwr_done)  state_d = ST_OFF;
      default:                  state_d = ST_OFF;
    endcase
  end

  always_comb begin
    alu_pwr_en = 1'b0;
    alu_iso_en = 1'b1;
    req_ready  = 1'b0;
    unique case (state_q)
      ST_PUP, ST_ISOSET: alu_pwr_en = 1'b1;
      ST_ISOREL, ST_RUN: begin alu_pwr_en = 1'b1; alu_iso_en = 1'b0; end
      ST_ON:             begin alu_pwr_en = 1'b1; alu_iso_en = 1'b0; req_ready = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    start_d = accept;
    rv_d    = complete || wdog_abort;
    err_d   = wdog_abort;
    res_d   = complete ? alu_result : res_q;
    if (accept) begin
      a_d  = A;
      b_d  = B;
      op_d = opcode;
    end
    run_cnt_d = run_cnt_q;
    if (state_q != ST_RUN)       run_cnt_d = 2'd0;
    else if (run_cnt_q != 2'd2)  run_cnt_d = run_cnt_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_q     <= '0;
      start_q   <= 1'b0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      run_cnt_q <= 2'd0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      res_q     <= res_d;
      start_q   <= start_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_opcode = op_q;
  assign alu_start  = start_q;
  assign res_valid  = rv_q;
  assign result     = res_q;
  assign res_err    = err_q;
  assign pwr_state  = state_q;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Scoreboard bench for alu_pwr_seq with a behavioural gated ALU (3-cycle busy).
module tb_alu_pwr_seq;
  import alu_pwr_pkg::*;

  localparam int DW = 16;
  localparam int OW = 4;
`ifdef ALU_PWR_WDOG_EN
  localparam int WD = 8;
`else
  localparam int WD = 64;
`endif
  localparam logic [OW-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;

  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, pd_req = 1'b0;
  logic [DW-1:0] A = '0, B = '0;
  logic [OW-1:0] opcode = '0;
  logic req_ready, alu_pwr_en, alu_iso_en, alu_start, res_valid, res_err;
  logic [DW-1:0] alu_A, alu_B, result;
  logic [OW-1:0] alu_opcode;
  logic [2:0] pwr_state;

  logic busy_m = 1'b0;
  logic [DW-1:0] res_m = '0;
  int lat = 0;
  bit hang = 1'b0;

  int tests = 0, fails = 0;
  typedef struct packed { logic [DW-1:0] res; logic err; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  alu_pwr_seq #(.DATA_W(DW), .OP_W(OW), .PWR_UP_CYC(4), .PWR_DN_CYC(2),
                .IDLE_CYC(16), .WDOG_CYC(WD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .A(A), .B(B), .opcode(opcode), .pd_req(pd_req),
    .alu_pwr_en(alu_pwr_en), .alu_iso_en(alu_iso_en), .alu_start(alu_start),
    .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
    .alu_busy(busy_m), .alu_result(res_m),
    .res_valid(res_valid), .result(result), .res_err(res_err), .pwr_state(pwr_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Gated ALU stand-in: busy for 3 cycles after start, or forever while hang is set.
  always @(posedge clk) begin
    if (alu_start) begin
      busy_m <= 1'b1;
      lat    <= 3;
      res_m  <= alu_f(alu_A, alu_B, alu_opcode);
    end else if (busy_m && !hang) begin
      if (lat == 1) busy_m <= 1'b0;
      lat <= lat - 1;
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (sb.size() == 0) check("spurious res_valid", res_valid, 1'b0);
      else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("res_err", res_err, mon_e.err);
      end
    end
  end

  // Isolation bracketing monitor
  logic pe_prev = 1'b0, iso_prev = 1'b1;
  int pup_cyc = 0, pwr_falls = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (iso_prev && !alu_iso_en) check("pwr cycles before iso release", pup_cyc, 4);
      if (pe_prev && !alu_pwr_en) begin
        check("iso set before pwr off", iso_prev, 1'b1);
        pwr_falls <= pwr_falls + 1;
      end
      pup_cyc <= (alu_pwr_en && !pe_prev) ? 1 :
                 (alu_pwr_en && alu_iso_en) ? pup_cyc + 1 : pup_cyc;
    end
    pe_prev  <= alu_pwr_en;
    iso_prev <= alu_iso_en;
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op,
                      input logic [DW-1:0] exp, input logic err, input logic pd);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; A = a; B = b; opcode = op; pd_req = pd;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) check("req_ready timeout", req_ready, 1'b1);
    else sb.push_back('{res: exp, err: err});
    @(posedge clk); #1;
    check("alu_start pulse", alu_start, 1'b1);
    check("alu_A latched", alu_A, a);
    req_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 200);
    if (!res_valid) check("res_valid timeout", res_valid, 1'b1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (pwr_state != s && n < 200) begin @(negedge clk); n++; end
    check(nm, pwr_state, s);
  endtask

  initial begin
    int n, falls0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst pwr_en", alu_pwr_en, 1'b0);
    check("rst iso_en", alu_iso_en, 1'b1);
    check("rst result", result, 16'h0);
    check("rst pwr_state", pwr_state, ST_OFF);
    check("rst req_ready", req_ready, 1'b0);
    check("rst res_valid", res_valid, 1'b0);
    check("rst res_err", res_err, 1'b0);
    rst_n = 1'b1;

    // cold request
    send(16'd5, 16'd3, OP_ADD, 16'd8, 1'b0, 1'b0);
    wait_res();
    @(negedge clk);
    check("ON after op", pwr_state, ST_ON);

    // back-to-back without a power cycle
    falls0 = pwr_falls;
    send(16'd10, 16'd4, OP_SUB, 16'd6, 1'b0, 1'b0);
    wait_res();
    send(16'hF0F0, 16'h0FF0, OP_AND, 16'h00F0, 1'b0, 1'b0);
    wait_res();
    check("no power cycle b2b", pwr_falls, falls0);

    // idle timeout: res_valid cycle is the first ON cycle
    n = 0;
    while (pwr_state == ST_ON && n < 100) begin n++; @(negedge clk); end
    check("idle ON cycles", n, 16);
    check("ISOSET state", pwr_state, ST_ISOSET);
    check("ISOSET iso", alu_iso_en, 1'b1);
    check("ISOSET pwr", alu_pwr_en, 1'b1);
    @(negedge clk);
    check("PDN pwr off", alu_pwr_en, 1'b0);
    wait_state(ST_OFF, "reach OFF after idle");
    check("result held in OFF", result, 16'h00F0);
    @(negedge clk);
    req_valid = 1'b1; A = 16'h00FF; B = 16'h0F0F; opcode = OP_XOR;
    wait_state(ST_ISOREL, "re-power to ISOREL");
    check("result held after re-power", result, 16'h00F0);
    send(16'h00FF, 16'h0F0F, OP_XOR, 16'h0FF0, 1'b0, 1'b0);
    wait_res();

    // pd_req during RUN is deferred until completion
    send(16'h1200, 16'h0034, OP_OR, 16'h1234, 1'b0, 1'b0);
    pd_req = 1'b1;
    wait_res();
    @(negedge clk);
    check("ISOSET after deferred pd", pwr_state, ST_ISOSET);
    pd_req = 1'b0;
    @(negedge clk);
    check("PDN state", pwr_state, ST_PDN);
    req_valid = 1'b1; A = 16'd7; B = 16'd2; opcode = OP_SUB;
    n = 0;
    while (pwr_state == ST_PDN && n < 50) begin @(negedge clk); n++; end
    check("PDN completes to OFF", pwr_state, ST_OFF);
    @(negedge clk);
    check("OFF re-powers", pwr_state, ST_PUP);
    send(16'd7, 16'd2, OP_SUB, 16'd5, 1'b0, 1'b0);
    wait_res();

    // pd_req and req_valid together in ON: request wins
    send(16'd3, 16'd4, OP_ADD, 16'd7, 1'b0, 1'b1);
    @(negedge clk);
    check("request beats pd_req", pwr_state, ST_RUN);
    wait_res();
    @(negedge clk);
    check("pd after simultaneous op", pwr_state, ST_ISOSET);
    pd_req = 1'b0;
    wait_state(ST_OFF, "reach OFF after pd");

`ifdef ALU_PWR_WDOG_EN
    // watchdog abort: result held, error flagged, forced power cycle
    hang = 1'b1;
    send(16'd1, 16'd1, OP_ADD, 16'd7, 1'b1, 1'b0);
    wait_res();
    @(negedge clk);
    check("wdog ISOSET", pwr_state, ST_ISOSET);
    hang = 1'b0;
    wait_state(ST_OFF, "reach OFF after wdog");
`endif

    repeat (5) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
